// File: rtl/spi_master.sv
// SPI mode-0 master: moves one BufferSize-bit word per transaction, MSB first,
// through a single-cycle start/done handshake with local logic.
module spi_master #(
  parameter int BufferSize = 32,
  parameter int ClkDiv     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BufferSize-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [BufferSize-1:0] rx_data,
  output logic                  sck,
  output logic                  ss,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int BW = $clog2(BufferSize);
  localparam logic [CW-1:0] DIV_LAST = CW'(ClkDiv - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BufferSize - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         div_cnt, div_next;
  logic [BW-1:0]         bit_cnt, bit_next;
  // The MSB leaves through mosi at accept time, so only the remaining bits are kept.
  logic [BufferSize-2:0] tx_shift, tx_next;
  logic [BufferSize-1:0] rx_shift, rx_next;
  logic [BufferSize-1:0] rx_data_next;
  logic                  sck_next, ss_next, mosi_next, busy_next, done_next;
  logic                  tick, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      sck      <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      div_cnt  <= div_next;
      bit_cnt  <= bit_next;
      tx_shift <= tx_next;
      rx_shift <= rx_next;
      rx_data  <= rx_data_next;
      sck      <= sck_next;
      ss       <= ss_next;
      mosi     <= mosi_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_next     = bit_cnt;
    tx_next      = tx_shift;
    rx_next      = rx_shift;
    rx_data_next = rx_data;
    sck_next     = sck;
    ss_next      = ss;
    mosi_next    = mosi;
    busy_next    = busy;
    done_next    = 1'b0;

    tick     = (div_cnt == DIV_LAST);
    div_next = tick ? '0 : div_cnt + 1'b1;
    // A new word can launch straight from the end of the gap without visiting IDLE.
    accept   = start && ((state == IDLE) || ((state == GAP) && tick));

    case (state)
      IDLE: begin
        div_next = '0;
      end
      LEAD: begin
        bit_next = '0;
        if (tick) begin
          sck_next   = 1'b1;
          rx_next    = {rx_shift[BufferSize-2:0], miso};
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sck_next = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            state_next = TRAIL;
          end else begin
            mosi_next  = tx_shift[BufferSize-2];
            tx_next    = tx_shift << 1;
            bit_next   = bit_cnt + 1'b1;
            state_next = LOW;
          end
        end
      end
      LOW: begin
        if (tick) begin
          sck_next   = 1'b1;
          rx_next    = {rx_shift[BufferSize-2:0], miso};
          state_next = HIGH;
        end
      end
      TRAIL: begin
        if (tick) begin
          ss_next      = 1'b1;
          mosi_next    = 1'b0;
          done_next    = 1'b1;
          rx_data_next = rx_shift;
          state_next   = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      tx_next    = tx_data[BufferSize-2:0];
      mosi_next  = tx_data[BufferSize-1];
      ss_next    = 1'b0;
      busy_next  = 1'b1;
      div_next   = '0;
      state_next = LEAD;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a 32-bit/ClkDiv=2 instance with loopback or a
// model slave, plus an 8-bit/ClkDiv=1 instance in loopback.
module tb_spi_master;

  localparam logic [31:0] SLAVE_WORD = 32'h12345678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] tx_data = '0;
  logic        busy, done, sck, ss, mosi, miso;
  logic [31:0] rx_data;

  logic        start8 = 1'b0;
  logic [7:0]  tx8 = '0;
  logic        busy8, done8, sck8, ss8, mosi8, miso8;
  logic [7:0]  rx8;

  logic        loop_mode = 1'b1;
  logic [31:0] slave_sr = '0;
  logic        ss_prev = 1'b1;
  logic        sck_prev = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int rise8_cnt = 0;
  int done_cnt = 0;
  int mosi0_cnt = 0;

  always #5 clk = ~clk;

  spi_master #(.BufferSize(32), .ClkDiv(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master #(.BufferSize(8), .ClkDiv(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .tx_data(tx8),
    .busy(busy8), .done(done8), .rx_data(rx8),
    .sck(sck8), .ss(ss8), .mosi(mosi8), .miso(miso8)
  );

  assign miso  = loop_mode ? mosi : slave_sr[31];
  assign miso8 = mosi8;

  // Model slave: loads its word on ss fall, shifts out on each sck fall.
  always @(ss or sck) begin
    if (ss_prev === 1'b1 && ss === 1'b0) slave_sr = SLAVE_WORD;
    else if (sck_prev === 1'b1 && sck === 1'b0 && ss === 1'b0) slave_sr = slave_sr << 1;
    ss_prev  = ss;
    sck_prev = sck;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge sck) rise_cnt <= rise_cnt + 1;
  always @(posedge sck8) rise8_cnt <= rise8_cnt + 1;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (ss === 1'b0 && mosi === 1'b0) mosi0_cnt <= mosi0_cnt + 1;
  end

  task automatic start_txn(input logic [31:0] tx, output int e0);
    @(negedge clk);
    start = 1'b1;
    tx_data = tx;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input int e0, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc - e0;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sck, ss, mosi, busy, done} !== 5'b01000) begin
      errors++;
      $display("[TB] FAIL reset_ctl: got %b expected 01000", {sck, ss, mosi, busy, done});
    end
    checks++;
    if (rx_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rx: got %h expected 00000000", rx_data);
    end
    checks++;
    if ({sck8, ss8, mosi8, busy8, done8} !== 5'b01000) begin
      errors++;
      $display("[TB] FAIL reset8_ctl: got %b expected 01000", {sck8, ss8, mosi8, busy8, done8});
    end
    checks++;
    if (rx8 !== 8'h0) begin
      errors++;
      $display("[TB] FAIL reset8_rx: got %h expected 00", rx8);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_loopback();
    int e0, at, r0, idle_at;
    logic done_after;
    loop_mode = 1'b1;
    r0 = rise_cnt;
    start_txn(32'hA5C30F81, e0);
    wait_done(e0, at);
    checks++;
    if (at !== 130) begin
      errors++;
      $display("[TB] FAIL t1_done_time: got %0d expected 130", at);
    end
    checks++;
    if (rx_data !== 32'hA5C30F81) begin
      errors++;
      $display("[TB] FAIL t1_rx: got %h expected a5c30f81", rx_data);
    end
    checks++;
    if (rise_cnt - r0 !== 32) begin
      errors++;
      $display("[TB] FAIL t1_sck_rises: got %0d expected 32", rise_cnt - r0);
    end
    @(negedge clk);
    done_after = done;
    checks++;
    if (done_after !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t1_done_pulse: got %b expected 0", done_after);
    end
    idle_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (busy === 1'b0) begin
        idle_at = cyc - e0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (idle_at !== 132) begin
      errors++;
      $display("[TB] FAIL t1_busy_low: got %0d expected 132", idle_at);
    end
  endtask

  task automatic test_slave();
    int e0, at, m0;
    loop_mode = 1'b0;
    m0 = mosi0_cnt;
    start_txn(32'hFFFFFFFF, e0);
    wait_done(e0, at);
    checks++;
    if (rx_data !== SLAVE_WORD) begin
      errors++;
      $display("[TB] FAIL t2_rx: got %h expected %h", rx_data, SLAVE_WORD);
    end
    checks++;
    if (mosi0_cnt - m0 !== 0) begin
      errors++;
      $display("[TB] FAIL t2_mosi_high: got %0d low samples expected 0", mosi0_cnt - m0);
    end
    checks++;
    if (at !== 130) begin
      errors++;
      $display("[TB] FAIL t2_done_time: got %0d expected 130", at);
    end
    wait_idle();
    loop_mode = 1'b1;
  endtask

  task automatic test_ignore_start();
    int e0, at, d0;
    loop_mode = 1'b1;
    d0 = done_cnt;
    start_txn(32'h0F0F3355, e0);
    for (int i = 0; i < 200 && (cyc - e0) < 10; i++) @(negedge clk);
    start = 1'b1;
    tx_data = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && (cyc - e0) < 60; i++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(e0, at);
    checks++;
    if (at !== 130) begin
      errors++;
      $display("[TB] FAIL t3_done_time: got %0d expected 130", at);
    end
    checks++;
    if (rx_data !== 32'h0F0F3355) begin
      errors++;
      $display("[TB] FAIL t3_rx: got %h expected 0f0f3355", rx_data);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL t3_done_count: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t3_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int e0a, e0b, at, ss_high;
    logic [31:0] rx1;
    logic got1, busy_dropped;
    loop_mode = 1'b1;
    got1 = 1'b0;
    busy_dropped = 1'b0;
    ss_high = 0;
    e0b = -1;
    rx1 = '0;
    @(negedge clk);
    start = 1'b1;
    tx_data = 32'h00000001;
    @(negedge clk);
    e0a = cyc;
    tx_data = 32'h80000000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_dropped = 1'b1;
      if (done === 1'b1 && !got1) begin
        got1 = 1'b1;
        rx1 = rx_data;
      end
      if (got1) begin
        if (ss === 1'b1) ss_high++;
        else begin
          e0b = cyc;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (rx1 !== 32'h00000001) begin
      errors++;
      $display("[TB] FAIL t4_rx1: got %h expected 00000001", rx1);
    end
    checks++;
    if (e0b - e0a !== 132) begin
      errors++;
      $display("[TB] FAIL t4_second_e0: got %0d expected 132", e0b - e0a);
    end
    checks++;
    if (ss_high !== 2) begin
      errors++;
      $display("[TB] FAIL t4_ss_gap: got %0d expected 2", ss_high);
    end
    checks++;
    if (busy_dropped !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t4_busy_held: got dropped=%b expected 0", busy_dropped);
    end
    wait_done(e0b, at);
    checks++;
    if (rx_data !== 32'h80000000 || at !== 130) begin
      errors++;
      $display("[TB] FAIL t4_rx2: got %h at %0d expected 80000000 at 130", rx_data, at);
    end
    wait_idle();
  endtask

  task automatic test_reset_abort();
    int e0, at, d0;
    loop_mode = 1'b1;
    d0 = done_cnt;
    start_txn(32'hCAFEF00D, e0);
    for (int i = 0; i < 200 && (cyc - e0) < 40; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sck, ss, busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL t5_abort: got sck,ss,busy=%b expected 010", {sck, ss, busy});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++;
      $display("[TB] FAIL t5_no_done: got %0d expected 0", done_cnt - d0);
    end
    checks++;
    if (rx_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL t5_rx: got %h expected 00000000", rx_data);
    end
    rst_n = 1'b1;
    start_txn(32'h13579BDF, e0);
    wait_done(e0, at);
    checks++;
    if (at !== 130) begin
      errors++;
      $display("[TB] FAIL t5_restart_time: got %0d expected 130", at);
    end
    checks++;
    if (rx_data !== 32'h13579BDF) begin
      errors++;
      $display("[TB] FAIL t5_restart_rx: got %h expected 13579bdf", rx_data);
    end
    wait_idle();
  endtask

  task automatic test_small();
    int e0, at, r0, last, per_bad;
    logic prev;
    at = -1;
    last = -1;
    per_bad = 0;
    @(negedge clk);
    start8 = 1'b1;
    tx8 = 8'h3C;
    @(negedge clk);
    start8 = 1'b0;
    e0 = cyc;
    r0 = rise8_cnt;
    prev = sck8;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sck8 === 1'b1 && prev === 1'b0) begin
        if (last >= 0 && (cyc - last) != 2) per_bad++;
        last = cyc;
      end
      prev = sck8;
      if (done8 === 1'b1 && at < 0) at = cyc - e0;
    end
    checks++;
    if (at !== 17) begin
      errors++;
      $display("[TB] FAIL t6_done_time: got %0d expected 17", at);
    end
    checks++;
    if (rx8 !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL t6_rx: got %h expected 3c", rx8);
    end
    checks++;
    if (rise8_cnt - r0 !== 8) begin
      errors++;
      $display("[TB] FAIL t6_sck_rises: got %0d expected 8", rise8_cnt - r0);
    end
    checks++;
    if (per_bad !== 0) begin
      errors++;
      $display("[TB] FAIL t6_sck_period: got %0d bad periods expected 0", per_bad);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t6_idle: got busy=%b expected 0", busy8);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
